// File: rtl/ncc_pkg.sv
// Shared types and default geometry for the NCC window controller.
package ncc_pkg;

  localparam int unsigned NCC_ROWS  = 16;
  localparam int unsigned NCC_COLS  = 80;
  localparam int unsigned NCC_PATCH = 16;
  localparam int unsigned NCC_AW    = 10;

  typedef logic [7:0] ncc_pixel_t;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StScan,
    StDrain,
    StDone
  } ncc_win_state_t;

endpackage

// File: rtl/ncc_col_fifo.sv
// Two-entry FIFO holding column vectors plus first/last flags on their way to the correlator.
module ncc_col_fifo #(
  parameter int unsigned WIDTH = 130
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wptr_q;
  logic             rptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             pop_ok;
  logic             push_ok;

  always_comb begin
    pop_ok  = pop && (count_q != 2'd0);
    push_ok = push && ((count_q != 2'd2) || pop_ok);
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= push_data;
        wptr_q        <= ~wptr_q;
      end
      if (pop_ok) begin
        rptr_q <= ~rptr_q;
      end
      count_q <= count_d;
    end
  end

  assign head  = mem_q[rptr_q];
  assign count = count_q;

endmodule

// File: rtl/ncc_window_ctrl.sv
// Loads a raster pixel stream into the per-row window BRAMs, then streams column
// vectors for every patch position to the correlator under valid/ready.
module ncc_window_ctrl
  import ncc_pkg::*;
#(
  parameter int unsigned ROWS  = NCC_ROWS,
  parameter int unsigned COLS  = NCC_COLS,
  parameter int unsigned PATCH = NCC_PATCH,
  parameter int unsigned AW    = NCC_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        pix_in,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic [ROWS-1:0]   win_we,
  output logic [AW-1:0]     win_waddr,
  output logic [7:0]        win_wdata,
  output logic [AW-1:0]     win_raddr,
  input  logic [ROWS*8-1:0] win_rdata,
  output logic [ROWS*8-1:0] col_data,
  output logic              col_valid,
  input  logic              col_ready,
  output logic              col_first,
  output logic              col_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW = (PATCH > 1) ? $clog2(PATCH) : 1;
  localparam int unsigned FW = ROWS * 8 + 2;

  localparam logic [RW-1:0] RowLast = RW'(ROWS - 1);
  localparam logic [AW-1:0] ColLast = AW'(COLS - 1);
  localparam logic [AW-1:0] PosLast = AW'(COLS - PATCH);
  localparam logic [CW-1:0] CLast   = CW'(PATCH - 1);

  ncc_win_state_t state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [AW-1:0]   col_q, col_d;
  logic [AW-1:0]   pos_q, pos_d;
  logic [CW-1:0]   c_q, c_d;
  logic            inflight_q, inflight_d;
  logic            infl_first_q, infl_first_d;
  logic            infl_last_q, infl_last_d;
  logic [ROWS-1:0] we_q, we_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  ncc_pixel_t      wdata_q, wdata_d;

  logic            accept;
  logic            issue;
  logic            pop;
  logic [1:0]      fifo_count;
  logic [1:0]      occupancy;
  logic [FW-1:0]   fifo_head;

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    pos_d        = pos_q;
    c_d          = c_q;
    we_d         = '0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;

    accept       = (state_q == StLoad) && pix_valid;
    pop          = col_valid && col_ready;
    // Occupancy after this cycle's pop, counting the read whose data lands next cycle;
    // issuing only below 2 keeps the FIFO from overflowing yet sustains 1 column/cycle.
    occupancy    = fifo_count - {1'b0, pop} + {1'b0, inflight_q};
    issue        = (state_q == StScan) && (occupancy < 2'd2);
    inflight_d   = issue;
    infl_first_d = issue && (c_q == '0);
    infl_last_d  = issue && (c_q == CLast);

    case (state_q)
      StIdle: begin
        if (start) begin
          row_d   = '0;
          col_d   = '0;
          pos_d   = '0;
          c_d     = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (accept) begin
          we_d    = ROWS'(1) << row_q;
          waddr_d = col_q;
          wdata_d = pix_in;
          if (col_q == ColLast) begin
            col_d = '0;
            if (row_q == RowLast) begin
              row_d   = '0;
              state_d = StScan;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      StScan: begin
        if (issue) begin
          if (c_q == CLast) begin
            c_d = '0;
            if (pos_q == PosLast) begin
              pos_d   = '0;
              state_d = StDrain;
            end else begin
              pos_d = pos_q + 1'b1;
            end
          end else begin
            c_d = c_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (!inflight_q && (fifo_count == 2'd0)) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      row_q        <= '0;
      col_q        <= '0;
      pos_q        <= '0;
      c_q          <= '0;
      inflight_q   <= 1'b0;
      infl_first_q <= 1'b0;
      infl_last_q  <= 1'b0;
      we_q         <= '0;
      waddr_q      <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      pos_q        <= pos_d;
      c_q          <= c_d;
      inflight_q   <= inflight_d;
      infl_first_q <= infl_first_d;
      infl_last_q  <= infl_last_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
    end
  end

  ncc_col_fifo #(
    .WIDTH(FW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight_q),
    .push_data({win_rdata, infl_first_q, infl_last_q}),
    .pop      (pop),
    .head     (fifo_head),
    .count    (fifo_count)
  );

  assign pix_ready = (state_q == StLoad);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign win_we    = we_q;
  assign win_waddr = waddr_q;
  assign win_wdata = wdata_q;
  assign win_raddr = pos_q + AW'(c_q);
  assign col_valid = (fifo_count != 2'd0);
  assign col_data  = fifo_head[FW-1:2];
  assign col_first = fifo_head[1];
  assign col_last  = fifo_head[0];

endmodule

// File: tb/tb_ncc_window_ctrl.sv
// Scoreboard bench for ncc_window_ctrl with a behavioural row-BRAM model.
module tb_ncc_window_ctrl;
  import ncc_pkg::*;

  localparam int ROWS  = 16;
  localparam int COLS  = 80;
  localparam int PATCH = 16;
  localparam int AW    = 10;
  localparam int NPIX  = ROWS * COLS;
  localparam int FW    = ROWS * 8 + 2;

  typedef struct packed {
    logic [ROWS-1:0] we;
    logic [AW-1:0]   addr;
    logic [7:0]      data;
  } wr_t;

  logic              clk;
  logic              rst;
  logic              start;
  logic [7:0]        pix_in;
  logic              pix_valid;
  logic              pix_ready;
  logic [ROWS-1:0]   win_we;
  logic [AW-1:0]     win_waddr;
  logic [7:0]        win_wdata;
  logic [AW-1:0]     win_raddr;
  logic [ROWS*8-1:0] win_rdata;
  logic [ROWS*8-1:0] col_data;
  logic              col_valid;
  logic              col_ready;
  logic              col_first;
  logic              col_last;
  logic              busy;
  logic              done;

  ncc_window_ctrl #(
    .ROWS (ROWS),
    .COLS (COLS),
    .PATCH(PATCH),
    .AW   (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pix_in   (pix_in),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .win_we   (win_we),
    .win_waddr(win_waddr),
    .win_wdata(win_wdata),
    .win_raddr(win_raddr),
    .win_rdata(win_rdata),
    .col_data (col_data),
    .col_valid(col_valid),
    .col_ready(col_ready),
    .col_first(col_first),
    .col_last (col_last),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row BRAMs: synchronous write on port A, 1-cycle registered read on port B.
  logic [7:0] bram [ROWS][1 << AW];
  always @(posedge clk) begin
    for (int r = 0; r < ROWS; r++) begin
      if (win_we[r]) bram[r][win_waddr] <= win_wdata;
      win_rdata[8*r +: 8] <= bram[r][win_raddr];
    end
  end

  int n_pass, n_total;
  int ready_mode, col_pops, wr_cnt, done_cnt, exp_done;
  bit stalled;
  logic [FW-1:0] sb_col [$];
  wr_t sb_wr [$];

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, want);
  endtask

  task automatic fail_now(input string name, input string why);
    n_total++;
    $display("FAIL %s: %s", name, why);
  endtask

  function automatic logic [7:0] pix(input int r, input int c);
    return 8'((r * COLS + c) % 256);
  endfunction

  task automatic push_expected_cols();
    logic [FW-1:0] v;
    for (int p = 0; p <= COLS - PATCH; p++) begin
      for (int c = 0; c < PATCH; c++) begin
        v = '0;
        for (int r = 0; r < ROWS; r++) v[2 + 8*r +: 8] = pix(r, p + c);
        v[1] = (c == 0);
        v[0] = (c == PATCH - 1);
        sb_col.push_back(v);
      end
    end
  endtask

  // Column monitor: drives col_ready and checks every presented head against the scoreboard.
  initial begin
    logic [FW-1:0] exp_v;
    col_ready = 1'b1;
    forever begin
      @(negedge clk);
      col_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled && !col_valid) fail_now("col_drop", "col_valid fell while stalled");
        if (col_valid) begin
          check("fifo_count_le2", 256'(dut.fifo_count <= 2'd2), 256'(1));
          if (sb_col.size() == 0) begin
            fail_now("col_unexpected", "column presented with empty scoreboard");
          end else begin
            exp_v = sb_col[0];
            check("column", 256'({col_data, col_first, col_last}), 256'(exp_v));
            if (col_ready) begin
              void'(sb_col.pop_front());
              col_pops++;
            end
          end
          stalled = !col_ready;
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  // Write and done monitor.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (!rst && (win_we != '0)) begin
        wr_cnt++;
        if (sb_wr.size() == 0) begin
          fail_now("write_unexpected", "write with no accepted pixel");
        end else begin
          w = sb_wr.pop_front();
          check("write", 256'({win_we, win_waddr, win_wdata}), 256'(w));
        end
      end
      if (!rst && done) done_cnt++;
    end
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_frame(input bit bursty, input bit poke);
    int  n;
    wr_t w;
    push_expected_cols();
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (bursty) repeat ((r * 3 + c) % 4) @(negedge clk);
        if (poke && r == 3 && c == 10) start = 1'b1;
        pix_in    = pix(r, c);
        pix_valid = 1'b1;
        n = 0;
        while (!pix_ready && n < 50) begin
          @(negedge clk);
          n++;
        end
        if (n >= 50) fail_now("pix_ready_wait", "pix_ready never rose");
        w.we   = ROWS'(1) << r;
        w.addr = AW'(c);
        w.data = pix(r, c);
        sb_wr.push_back(w);
        @(negedge clk);
        pix_valid = 1'b0;
        start     = 1'b0;
      end
    end
    check("pix_ready_after_last", 256'(pix_ready), 256'(0));
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (done_cnt < exp_done && cycles < 6000) begin
      @(negedge clk);
      cycles++;
    end
    if (cycles >= 6000) begin
      fail_now("done_timeout", "done never pulsed");
    end else begin
      @(negedge clk);
      check("busy_after_done", 256'(busy), 256'(0));
      check("done_one_cycle", 256'(done), 256'(0));
    end
    repeat (5) @(negedge clk);
    check("done_count", 256'(done_cnt), 256'(exp_done));
    check("busy_idle", 256'(busy), 256'(0));
    check("cols_left", 256'(sb_col.size()), 256'(0));
    check("write_count", 256'(wr_cnt), 256'(NPIX));
  endtask

  task automatic run_scan(input bit bursty, input bit poke, input int rmode);
    int cycles;
    ready_mode = rmode;
    wr_cnt     = 0;
    do_start();
    check("busy_in_load", 256'(busy), 256'(1));
    load_frame(bursty, poke);
    if (poke) begin
      repeat (20) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    exp_done++;
    wait_done(cycles);
    if (rmode == 0 && !poke) check("scan_throughput", 256'(cycles <= 1050), 256'(1));
  endtask

  initial begin
    int n;
    n_pass = 0; n_total = 0; col_pops = 0; wr_cnt = 0; done_cnt = 0; exp_done = 0;
    ready_mode = 0; stalled = 1'b0;
    rst = 1'b1; start = 1'b0; pix_in = '0; pix_valid = 1'b0;
    #12;
    check("reset_outputs", 256'({pix_ready, win_we, win_waddr, win_wdata, win_raddr, col_data,
                                 col_valid, col_first, col_last, busy, done}), 256'(0));
    @(negedge clk);
    rst = 1'b0;

    run_scan(1'b0, 1'b0, 0);
    run_scan(1'b0, 1'b0, 1);
    run_scan(1'b1, 1'b1, 0);

    // Reset in the middle of the scan, then reload and rescan.
    ready_mode = 0;
    wr_cnt     = 0;
    do_start();
    load_frame(1'b0, 1'b0);
    col_pops = 0;
    n = 0;
    while (col_pops < 500 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) fail_now("mid_scan_wait", "500 columns never reached");
    rst = 1'b1;
    #1;
    check("midscan_reset_outputs", 256'({pix_ready, win_we, win_waddr, win_wdata, win_raddr,
                                         col_data, col_valid, col_first, col_last, busy, done}),
          256'(0));
    sb_col.delete();
    sb_wr.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_scan(1'b0, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "watchdog");
  end

endmodule
